// File: rtl/egress_drain_reader.sv
// Drains destination FIFOs D0/D1 into one valid/ready stream, checks each word's
// destination bit and counts deliveries. Macro EGRESS_RR_EN selects round-robin (default: D0 priority).
module egress_drain_reader #(
    parameter int DW = 6,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d0_empty,
    input  logic          d1_empty,
    input  logic [DW-1:0] data_out0,
    input  logic [DW-1:0] data_out1,
    input  logic          pause,
    input  logic          cnt_clr,
    output logic          pop_D0,
    output logic          pop_D1,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_dest,
    output logic [CW-1:0] cnt_d0,
    output logic [CW-1:0] cnt_d1,
    output logic          busy,
    output logic          error_out
);
    localparam int DEST_BIT = 4;

    typedef enum logic [1:0] {IDLE, POP, WAIT, HOLD} state_t;

    state_t        r_state;
    logic          r_grant;
    logic          r_last_grant;
    logic          r_pop_d0;
    logic          r_pop_d1;
    logic          r_out_valid;
    logic          r_out_dest;
    logic          r_error;
    logic [DW-1:0] r_out_data;

    logic          w_start;
    logic          w_next_grant;
    logic          w_xfer;
    logic [DW-1:0] w_sel_data;
    logic [CW-1:0] w_cnt [2];

    assign w_start    = ~pause & (~d0_empty | ~d1_empty);
    assign w_xfer     = r_out_valid & out_ready;
    assign w_sel_data = r_grant ? data_out1 : data_out0;

    // With nothing to serve the grant is irrelevant; keep the previous one.
    always_comb begin
        w_next_grant = r_last_grant;
`ifdef EGRESS_RR_EN
        if (!d0_empty && !d1_empty)
            w_next_grant = ~r_last_grant;
        else if (!d0_empty)
            w_next_grant = 1'b0;
        else if (!d1_empty)
            w_next_grant = 1'b1;
`else
        if (!d0_empty)
            w_next_grant = 1'b0;
        else if (!d1_empty)
            w_next_grant = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_pop_d0     <= 1'b0;
            r_pop_d1     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_dest   <= 1'b0;
            r_out_data   <= '0;
            r_error      <= 1'b0;
        end else begin
            r_pop_d0 <= 1'b0;
            r_pop_d1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_grant  <= w_next_grant;
                        r_pop_d0 <= ~w_next_grant;
                        r_pop_d1 <= w_next_grant;
                        r_state  <= POP;
                    end
                end
                POP: r_state <= WAIT;
                WAIT: begin
                    // FIFO read data is valid now, one cycle after the pop strobe.
                    r_out_data   <= w_sel_data;
                    r_out_dest   <= r_grant;
                    r_out_valid  <= 1'b1;
                    r_last_grant <= r_grant;
                    if (w_sel_data[DEST_BIT] != r_grant)
                        r_error <= 1'b1;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        if (w_start) begin
                            r_grant  <= w_next_grant;
                            r_pop_d0 <= ~w_next_grant;
                            r_pop_d1 <= w_next_grant;
                            r_state  <= POP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-destination saturating delivery counters; clear wins over increment.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CW-1:0] r_cnt;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_cnt <= '0;
                else if (cnt_clr)
                    r_cnt <= '0;
                else if (w_xfer && (r_out_dest == 1'(gi)) && (r_cnt != {CW{1'b1}}))
                    r_cnt <= r_cnt + 1'b1;
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign pop_D0    = r_pop_d0;
    assign pop_D1    = r_pop_d1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_dest  = r_out_dest;
    assign cnt_d0    = w_cnt[0];
    assign cnt_d1    = w_cnt[1];
    assign busy      = (r_state != IDLE);
    assign error_out = r_error;
endmodule

// File: tb/tb_egress_drain_reader.sv
// Self-checking bench for egress_drain_reader: FIFO models, directed sequences,
// a vector table and randomized rounds against a transaction-level order model.
module tb_egress_drain_reader;
    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pause = 1'b1;
    logic          cnt_clr = 1'b0;
    logic          out_ready = 1'b0;
    logic          d0_empty;
    logic          d1_empty;
    logic [DW-1:0] data_out0 = '0;
    logic [DW-1:0] data_out1 = '0;
    logic          pop_D0;
    logic          pop_D1;
    logic          out_valid;
    logic          out_dest;
    logic          busy;
    logic          error_out;
    logic [DW-1:0] out_data;
    logic [CW-1:0] cnt_d0;
    logic [CW-1:0] cnt_d1;

    egress_drain_reader #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .d0_empty(d0_empty), .d1_empty(d1_empty),
        .data_out0(data_out0), .data_out1(data_out1), .pause(pause), .cnt_clr(cnt_clr),
        .pop_D0(pop_D0), .pop_D1(pop_D1), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_dest(out_dest), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1),
        .busy(busy), .error_out(error_out)
    );

    always #5 clk = ~clk;

    // FIFO models: read data appears the cycle after a pop.
    logic [DW-1:0] mem0 [1024];
    logic [DW-1:0] mem1 [1024];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    assign d0_empty = (rd0 == wr0);
    assign d1_empty = (rd1 == wr1);
    always @(posedge clk) begin
        if (pop_D0) begin data_out0 <= mem0[rd0[9:0]]; rd0 <= rd0 + 1; end
        if (pop_D1) begin data_out1 <= mem1[rd1[9:0]]; rd1 <= rd1 + 1; end
    end

    task automatic push0(input logic [DW-1:0] w); mem0[wr0[9:0]] = w; wr0 = wr0 + 1; endtask
    task automatic push1(input logic [DW-1:0] w); mem1[wr1[9:0]] = w; wr1 = wr1 + 1; endtask

    int checks = 0, passes = 0, fails = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: records deliveries and checks protocol rules every cycle.
    logic [DW-1:0] got_data [$];
    logic          got_dest [$];
    int            pop_cyc [$];
    int            vrise_cyc [$];
    int            cyc = 0;
    logic          prev_hold = 1'b0, prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [CW-1:0] prev_c0 = '0, prev_c1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (pop_D0 || pop_D1) begin
                chk("pop_excl", int'(pop_D0 & pop_D1), 0);
                chk("pop_empty", int'((pop_D0 & d0_empty) | (pop_D1 & d1_empty)), 0);
                pop_cyc.push_back(cyc);
            end
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_data));
                chk("hold_pop", int'(pop_D0 | pop_D1), 0);
                chk("hold_cnt", int'({cnt_d0, cnt_d1}), int'({prev_c0, prev_c1}));
            end
            if (out_valid && !prev_valid) vrise_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_dest.push_back(out_dest);
                $display("xfer: data=0x%02h dest=%0d cyc=%0d", out_data, out_dest, cyc);
            end
            prev_hold  = out_valid & ~out_ready & ~cnt_clr;
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_c0    = cnt_d0;
            prev_c1    = cnt_d1;
        end
    end

    task automatic tick(); @(negedge clk); #1; endtask

    task automatic clear_logs();
        got_data.delete(); got_dest.delete(); pop_cyc.delete(); vrise_cyc.delete();
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got_data.size() < n && k < budget) begin tick(); k++; end
        if (got_data.size() < n) chk("timeout_got", got_data.size(), n);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin tick(); k++; end
        if (!out_valid) chk("timeout_valid", int'(out_valid), 1);
    endtask

    task automatic wait_pop(input int budget);
        int k = 0;
        while (!(pop_D0 || pop_D1) && k < budget) begin tick(); k++; end
        if (!(pop_D0 || pop_D1)) chk("timeout_pop", int'(pop_D0 | pop_D1), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        if (busy) chk("timeout_idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
    endtask

    typedef struct {
        logic          src;
        logic [DW-1:0] word;
        int            hold;
        logic [DW-1:0] exp_data;
        logic          exp_dest;
        logic          exp_err;
    } vec_t;

    vec_t          tbl [7];
    logic [DW-1:0] exp_d [$];
    logic          exp_s [$];
    logic [DW-1:0] w0 [$];
    logic [DW-1:0] w1 [$];
    logic [DW-1:0] w;
    logic [DW-1:0] exp2 [4];
    logic          exps2 [4];
    logic          g;
    logic          last;
    logic          merr;
    int            e0, e1, m0, m1, n0, n1, i0, i1, k, bad;

    initial begin
        tbl[0] = '{1'b0, 6'h05, 0, 6'h05, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 6'h17, 2, 6'h17, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 6'h2D, 5, 6'h2D, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 6'h1B, 1, 6'h1B, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 6'h3F, 0, 6'h3F, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 6'h0C, 3, 6'h0C, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 6'h21, 1, 6'h21, 1'b0, 1'b1};

        // Reset state
        tick(); tick();
        chk("rst_pop0", int'(pop_D0), 0);
        chk("rst_pop1", int'(pop_D1), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_dest", int'(out_dest), 0);
        chk("rst_cnt0", int'(cnt_d0), 0);
        chk("rst_cnt1", int'(cnt_d1), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(error_out), 0);

        // D0-only stream released out of reset: latency and throughput
        clear_logs();
        push0(6'h0B); push0(6'h03);
        pause = 1'b0; out_ready = 1'b1;
        reset = 1'b0;
        wait_got(2, 30);
        wait_idle(10);
        chk("t1_w0", int'(got_data[0]), 'h0B);
        chk("t1_w1", int'(got_data[1]), 'h03);
        chk("t1_dest", int'({got_dest[0], got_dest[1]}), 0);
        if (pop_cyc.size() >= 2 && vrise_cyc.size() >= 1) begin
            chk("t1_latency", vrise_cyc[0] - pop_cyc[0], 2);
            chk("t1_period", pop_cyc[1] - pop_cyc[0], 3);
        end else begin
            chk("t1_pops", pop_cyc.size(), 2);
        end
        chk("t1_cnt0", int'(cnt_d0), 2);
        chk("t1_cnt1", int'(cnt_d1), 0);
        chk("t1_err", int'(error_out), 0);
        chk("t1_busy", int'(busy), 0);

        // Both FIFOs loaded: arbitration order
        pause = 1'b1; do_reset(); clear_logs();
        push0(6'h09); push0(6'h0A); push1(6'h1B); push1(6'h1D);
        pause = 1'b0;
`ifdef EGRESS_RR_EN
        exp2 = '{6'h09, 6'h1B, 6'h0A, 6'h1D}; exps2 = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp2 = '{6'h09, 6'h0A, 6'h1B, 6'h1D}; exps2 = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
        wait_got(4, 40);
        wait_idle(10);
        for (int i = 0; i < 4; i++) begin
            chk("arb_data", int'(got_data[i]), int'(exp2[i]));
            chk("arb_dest", int'(got_dest[i]), int'(exps2[i]));
        end
        chk("arb_cnt0", int'(cnt_d0), 2);
        chk("arb_cnt1", int'(cnt_d1), 2);
        chk("arb_err", int'(error_out), 0);

        // Vector table: single words with backpressure and destination checks
        e0 = 2; e1 = 2;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            if (tbl[i].src) push1(tbl[i].word); else push0(tbl[i].word);
            wait_valid(10);
            chk("tbl_data", int'(out_data), int'(tbl[i].exp_data));
            chk("tbl_dest", int'(out_dest), int'(tbl[i].exp_dest));
            chk("tbl_err", int'(error_out), int'(tbl[i].exp_err));
            repeat (tbl[i].hold) tick();
            chk("tbl_held", int'(out_data), int'(tbl[i].exp_data));
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            if (tbl[i].exp_dest) e1++; else e0++;
            chk("tbl_cnt0", int'(cnt_d0), e0);
            chk("tbl_cnt1", int'(cnt_d1), e1);
            chk("tbl_valid_drop", int'(out_valid), 0);
            wait_idle(10);
        end

        // pause raised the cycle after a pop: word completes, then no pops
        clear_logs();
        out_ready = 1'b1;
        push0(6'h01); push0(6'h02);
        wait_pop(10);
        tick(); pause = 1'b1;
        wait_got(1, 10);
        wait_idle(10);
        chk("pause_w0", int'(got_data[0]), 'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pause_nopop", int'(pop_D0 | pop_D1), 0);
            chk("pause_busy", int'(busy), 0);
        end
        pause = 1'b0; tick();
        chk("pause_resume", int'(pop_D0), 1);
        wait_got(2, 10);
        wait_idle(10);
        chk("pause_w1", int'(got_data[1]), 'h02);
        e0 = e0 + 2;
        chk("pause_cnt0", int'(cnt_d0), e0);

        // Reset during WAIT drops the in-flight word
        clear_logs();
        push0(6'h04);
        wait_pop(10);
        tick();
        reset = 1'b1; #1;
        chk("rw_valid", int'(out_valid), 0);
        chk("rw_data", int'(out_data), 0);
        chk("rw_pops", int'({pop_D0, pop_D1}), 0);
        chk("rw_busy", int'(busy), 0);
        chk("rw_err", int'(error_out), 0);
        chk("rw_cnt", int'({cnt_d0, cnt_d1}), 0);
        push0(6'h06); push1(6'h16);
        tick(); tick();
        chk("rw_dropped", got_data.size(), 0);
        reset = 1'b0;
        wait_got(2, 20);
        wait_idle(10);
        chk("rw_first", int'(got_data[0]), 'h06);
        chk("rw_first_dest", int'(got_dest[0]), 0);
        chk("rw_second", int'(got_data[1]), 'h16);
        chk("rw_cnt_after", int'({cnt_d0, cnt_d1}), 'h0101);

        // Counter saturation
        pause = 1'b1; do_reset(); clear_logs();
        for (int i = 0; i < 257; i++) begin
            w = 6'(i); w[4] = 1'b0; push0(w);
        end
        pause = 1'b0; out_ready = 1'b1;
        wait_got(257, 900);
        wait_idle(10);
        bad = 0;
        for (int i = 0; i < 257; i++) begin
            w = 6'(i); w[4] = 1'b0;
            if (i >= got_data.size() || got_data[i] != w) bad++;
        end
        chk("sat_order", bad, 0);
        chk("sat_cnt0", int'(cnt_d0), 255);
        chk("sat_cnt1", int'(cnt_d1), 0);
        chk("sat_err", int'(error_out), 0);

        // cnt_clr beats a same-cycle increment
        clear_logs();
        out_ready = 1'b0;
        push1(6'h11);
        wait_valid(10);
        out_ready = 1'b1; cnt_clr = 1'b1; tick(); cnt_clr = 1'b0; out_ready = 1'b0;
        chk("clr_cnt0", int'(cnt_d0), 0);
        chk("clr_cnt1", int'(cnt_d1), 0);
        wait_idle(10);
        push1(6'h12); out_ready = 1'b1;
        wait_got(2, 10);
        wait_idle(10);
        chk("clr_after_cnt1", int'(cnt_d1), 1);
        chk("clr_after_cnt0", int'(cnt_d0), 0);

        // Randomized rounds against the order model
        pause = 1'b1; do_reset();
        last = 1'b1; merr = 1'b0; m0 = 0; m1 = 0;
        for (int r = 0; r < 6; r++) begin
            clear_logs(); w0.delete(); w1.delete(); exp_d.delete(); exp_s.delete();
            n0 = $urandom_range(0, 10); n1 = $urandom_range(0, 10);
            for (int i = 0; i < n0; i++) begin
                w = 6'($urandom); w0.push_back(w); push0(w);
                if (w[4] != 1'b0) merr = 1'b1;
            end
            for (int i = 0; i < n1; i++) begin
                w = 6'($urandom); w1.push_back(w); push1(w);
                if (w[4] != 1'b1) merr = 1'b1;
            end
            i0 = 0; i1 = 0;
            while (i0 < n0 || i1 < n1) begin
                if (i0 < n0 && i1 < n1) begin
`ifdef EGRESS_RR_EN
                    g = ~last;
`else
                    g = 1'b0;
`endif
                end else begin
                    g = (i0 < n0) ? 1'b0 : 1'b1;
                end
                if (g) begin exp_d.push_back(w1[i1]); i1++; end
                else begin exp_d.push_back(w0[i0]); i0++; end
                exp_s.push_back(g);
`ifdef EGRESS_RR_EN
                last = g;
`endif
            end
            k = 0;
            while (got_data.size() < n0 + n1 && k < 400) begin
                pause = ($urandom_range(0, 3) == 0);
                out_ready = ($urandom_range(0, 2) != 0);
                tick(); k++;
            end
            if (got_data.size() < n0 + n1) chk("rnd_timeout", got_data.size(), n0 + n1);
            pause = 1'b0; out_ready = 1'b1;
            wait_idle(10);
            for (int i = 0; i < n0 + n1; i++) begin
                chk("rnd_data", int'(got_data[i]), int'(exp_d[i]));
                chk("rnd_dest", int'(got_dest[i]), int'(exp_s[i]));
            end
            m0 = m0 + n0; m1 = m1 + n1;
            chk("rnd_cnt0", int'(cnt_d0), m0);
            chk("rnd_cnt1", int'(cnt_d1), m1);
            chk("rnd_err", int'(error_out), int'(merr));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks so far %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
